// File: rtl/alu_defs.sv
// Shared ALU control codes, default widths and sequencer state encoding
// for the ALU-sharing arbiter.
package alu_defs;

  localparam int unsigned ALU_WORD = 32;
  localparam int unsigned ALU_OPW  = 4;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select: on contention the requester that was
// not served last wins.
module rr_pick2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic any,
  output logic winner
);

  always_comb begin
    any    = valid0 | valid1;
    winner = (valid0 & valid1) ? ~last_grant : valid1;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between two requesters:
// accept one op, drive the ALU from registered operands, return the result.
module alu_share_arbiter
  import alu_defs::*;
#(
  parameter int unsigned WORD = ALU_WORD,
  parameter int unsigned OPW  = ALU_OPW
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [WORD-1:0] req0_a,
  input  logic [WORD-1:0] req0_b,
  input  logic [OPW-1:0]  req0_op,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic [WORD-1:0] resp0_result,
  output logic            resp0_zero,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [WORD-1:0] req1_a,
  input  logic [WORD-1:0] req1_b,
  input  logic [OPW-1:0]  req1_op,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [WORD-1:0] resp1_result,
  output logic            resp1_zero,

  output logic [WORD-1:0] alu_a,
  output logic [WORD-1:0] alu_b,
  output logic [OPW-1:0]  alu_control,
  input  logic [WORD-1:0] alu_result,
  input  logic            alu_zero
);

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [WORD-1:0] op_a_q, op_a_d;
  logic [WORD-1:0] op_b_q, op_b_d;
  logic [OPW-1:0]  op_code_q, op_code_d;
  logic [WORD-1:0] res_q, res_d;
  logic            zero_q, zero_d;

  logic pick_any;
  logic pick_winner;

  rr_pick2 u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      res_q        <= res_d;
      zero_q       <= zero_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    res_d        = res_q;
    zero_d       = zero_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    resp0_valid  = 1'b0;
    resp1_valid  = 1'b0;
    resp0_result = '0;
    resp1_result = '0;
    resp0_zero   = 1'b0;
    resp1_zero   = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_control  = '0;

    // ALU sees the captured operation for the whole EXEC/RESP window
    if (state_q == ST_EXEC || state_q == ST_RESP) begin
      alu_a       = op_a_q;
      alu_b       = op_b_q;
      alu_control = op_code_q;
    end

    case (state_q)
      ST_IDLE: begin
        // A request seen while reset is high would be dropped, so never ack it
        if (pick_any && !reset) begin
          req0_ready = ~pick_winner;
          req1_ready = pick_winner;
          grant_d    = pick_winner;
          op_a_d     = pick_winner ? req1_a  : req0_a;
          op_b_d     = pick_winner ? req1_b  : req0_b;
          op_code_d  = pick_winner ? req1_op : req0_op;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!grant_q) begin
          resp0_valid  = 1'b1;
          resp0_result = res_q;
          resp0_zero   = zero_q;
          if (resp0_ready) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end else begin
          resp1_valid  = 1'b1;
          resp1_result = res_q;
          resp1_zero   = zero_q;
          if (resp1_ready) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the sharing rules.
module tb_alu_share_arbiter;
  import alu_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
  logic        req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero;

  int errors = 0;
  int checks = 0;

  // Transaction-level model state
  logic        busy;
  int          age;
  logic        exp_port;
  logic        last_srv;
  logic [31:0] ea, eb, eres;
  logic [3:0]  eop;
  logic        ez;
  logic        order[$];

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_op      (req0_op),
    .resp0_valid  (resp0_valid),
    .resp0_ready  (resp0_ready),
    .resp0_result (resp0_result),
    .resp0_zero   (resp0_zero),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_op      (req1_op),
    .resp1_valid  (resp1_valid),
    .resp1_ready  (resp1_ready),
    .resp1_result (resp1_result),
    .resp1_zero   (resp1_zero),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero)
  );

  // Reference ALU arithmetic: {zero, result}
  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // The shared ALU instance sitting beside the arbiter
  always_comb {alu_zero, alu_result} = alu_ref(alu_control, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] op);
    if (p) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // Mid-cycle: compare every output with the model, then advance the model
  task automatic settle();
    logic [1:0] rdy;
    logic       show;
    logic       p;
    @(negedge clk);
    rdy = 2'b00;
    if (!reset && !busy) begin
      rdy[0] = req0_valid && (!req1_valid || last_srv);
      rdy[1] = req1_valid && (!req0_valid || !last_srv);
    end
    show = busy && (age >= 2);
    chk("req0_ready", 32'(req0_ready), 32'(rdy[0]));
    chk("req1_ready", 32'(req1_ready), 32'(rdy[1]));
    chk("resp0_valid", 32'(resp0_valid), 32'(show && !exp_port));
    chk("resp1_valid", 32'(resp1_valid), 32'(show && exp_port));
    chk("resp0_result", resp0_result, (show && !exp_port) ? eres : 32'd0);
    chk("resp1_result", resp1_result, (show && exp_port) ? eres : 32'd0);
    chk("resp0_zero", 32'(resp0_zero), 32'(show && !exp_port && ez));
    chk("resp1_zero", 32'(resp1_zero), 32'(show && exp_port && ez));
    chk("alu_a", alu_a, busy ? ea : 32'd0);
    chk("alu_b", alu_b, busy ? eb : 32'd0);
    chk("alu_control", 32'(alu_control), busy ? 32'(eop) : 32'd0);
    if (reset) begin
      busy = 1'b0;
      last_srv = 1'b1;
    end else if (!busy) begin
      if (rdy != 2'b00) begin
        p        = rdy[1];
        busy     = 1'b1;
        age      = 1;
        exp_port = p;
        ea       = p ? req1_a : req0_a;
        eb       = p ? req1_b : req0_b;
        eop      = p ? req1_op : req0_op;
        {ez, eres} = alu_ref(eop, ea, eb);
        order.push_back(p);
      end
    end else if (age >= 2) begin
      if (exp_port ? resp1_ready : resp0_ready) begin
        busy = 1'b0;
        last_srv = exp_port;
      end
    end else begin
      age++;
    end
  endtask

  // One directed transaction on port p with `stall` cycles of response backpressure
  task automatic txn(input logic p, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input logic [31:0] r, input logic z,
                     input int stall);
    drive(p, 1'b1, a, b, op);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    settle();
    chk("txn_accept", 32'(p ? req1_ready : req0_ready), 32'd1);
    adv();
    drive(p, 1'b0, a, b, op);
    settle();
    chk("txn_exec_no_resp", 32'(p ? resp1_valid : resp0_valid), 32'd0);
    adv();
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) begin
        if (p) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      end
      settle();
      chk("txn_resp_valid", 32'(p ? resp1_valid : resp0_valid), 32'd1);
      chk("txn_resp_result", p ? resp1_result : resp0_result, r);
      chk("txn_resp_zero", 32'(p ? resp1_zero : resp0_zero), 32'(z));
      chk("txn_other_resp", 32'(p ? resp0_valid : resp1_valid), 32'd0);
      chk("txn_other_ready", 32'(p ? req0_ready : req1_ready), 32'd0);
      adv();
    end
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] opt [6];
    opt = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, 4'hF};
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; resp0_ready = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; resp1_ready = 1'b0;
    busy = 1'b0; age = 0; exp_port = 1'b0; last_srv = 1'b1;
    ea = '0; eb = '0; eop = '0; eres = '0; ez = 1'b0;

    // Reset state, then both requesters held valid: grants must alternate from 0
    adv();
    settle(); adv();
    settle(); adv();
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'd1, 32'd2, ALU_ADD);
    drive(1'b1, 1'b1, 32'hF0, 32'h0F, ALU_OR);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    order.delete();
    for (int i = 0; i < 24; i++) begin settle(); adv(); end
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin settle(); adv(); end
    chk("grant_order_len", 32'(order.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) chk("grant_order", 32'(order[i]), 32'(i % 2));
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;

    txn(1'b0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0, 0);
    txn(1'b1, 32'h10, 32'h10, ALU_SUB, 32'd0, 1'b1, 0);

    // Backpressure on requester 0 while requester 1 waits
    drive(1'b1, 1'b1, 32'hFF00, 32'h0FF0, ALU_AND);
    txn(1'b0, 32'd3, 32'd9, ALU_SLT, 32'd1, 1'b0, 5);
    txn(1'b1, 32'hFF00, 32'h0FF0, ALU_AND, 32'h0F00, 1'b0, 0);

    txn(1'b0, 32'd9, 32'd9, 4'b1111, 32'd0, 1'b1, 0);

    // Reset during EXEC aborts the operation without a response
    drive(1'b0, 1'b1, 32'd4, 32'd4, ALU_ADD);
    resp0_ready = 1'b1;
    settle();
    chk("abort_accept", 32'(req0_ready), 32'd1);
    adv();
    drive(1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    settle(); adv();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("abort_no_resp", 32'(resp0_valid), 32'd0);
      chk("abort_alu_idle", alu_a, 32'd0);
      adv();
    end
    drive(1'b1, 1'b1, 32'd6, 32'd1, ALU_SUB);
    txn(1'b0, 32'd4, 32'd4, ALU_ADD, 32'd8, 1'b0, 0);
    txn(1'b1, 32'd6, 32'd1, ALU_SUB, 32'd5, 1'b0, 1);

    // Random traffic with random backpressure and requests dropping unserved
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a, b;
        a = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(3, 0)) : 32'($urandom);
        b = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(3, 0)) : 32'($urandom);
        drive(1'(p), 1'($urandom_range(2, 0) != 0), a, b,
              ($urandom_range(7, 0) == 0) ? 4'($urandom) : opt[$urandom_range(5, 0)]);
      end
      resp0_ready = 1'($urandom_range(1, 0));
      resp1_ready = 1'($urandom_range(1, 0));
      settle();
      adv();
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin settle(); adv(); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Two-port round-robin arbiter and sequencer that time-shares one combinational ALU instance between two requesters, e.g. the EX stage and a branch-compare/address unit.
- Accepts one operation at a time over a valid/ready handshake, registers the operands, and drives the ALU from those registers.
- Captures the ALU result and zero flag, then returns them to the granted requester over a valid/ready response handshake.
- Sits between the requesters and the ALU; the ALU instance stays outside this block.

Parameters:
- WORD, 32, operand/result width (matches ALU `word`)
- OPW, 4, ALU control width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WORD  operand a
- req0_b  in  WORD  operand b
- req0_op  in  OPW  ALU control code
- resp0_valid  out  1  result available for requester 0
- resp0_ready  in  1  requester 0 consumes result
- resp0_result  out  WORD  result
- resp0_zero  out  1  zero flag
- req1_valid, req1_ready, req1_a, req1_b, req1_op, resp1_valid, resp1_ready, resp1_result, resp1_zero  same as port 0
- alu_a  out  WORD  to ALU a
- alu_b  out  WORD  to ALU b
- alu_control  out  OPW  to ALU control
- alu_result  in  WORD  from ALU result
- alu_zero  in  1  from ALU zero

Behaviour:
- Clocking: one clock `clk`; `reset` is synchronous and active-high. All state updates on the rising edge of `clk`.
- Reset values:
  - state=IDLE, grant=0, last_grant=1 (so requester 0 wins first).
  - All operand/result registers 0.
  - All ready/valid outputs 0; alu_a/alu_b/alu_control 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and asserted only for the winner, only in IDLE.
  - Winner: if exactly one valid, that one. If both valid, the one not equal to last_grant.
  - On a handshake (valid & ready): latch a/b/op into op_a/op_b/op_code, set grant=winner, go EXEC.
  - No valid: stay IDLE.
- EXEC:
  - alu_a/alu_b/alu_control are driven from op_a/op_b/op_code. They are also driven from these registers in RESP, and are 0 in IDLE.
  - At the clock edge, capture alu_result→res_q and alu_zero→zero_q, then go RESP.
- RESP:
  - respN_valid=1 for N=grant only; respN_result=res_q, respN_zero=zero_q. The non-granted resp outputs are 0.
  - Hold all values stable until respN_ready=1.
  - On handshake: last_grant=grant, go IDLE.
  - No request is accepted in RESP; reqN_ready=0 in EXEC and RESP.
- Latency: handshake accepted in cycle T → resp_valid in cycle T+2. Peak throughput is 1 op per 3 cycles.
- Fairness: with both requesters continuously valid and responses consumed immediately, grants alternate 0,1,0,1…
- Op codes are passed through unchecked. An unsupported code yields the ALU default result 0, zero=1, and is returned normally.
- resp_ready asserted while resp_valid=0 is ignored.
- Reset in any state aborts the transaction immediately: no response is issued, and pending requesters must re-present their request.
- Requester valid may drop without handshake; no state change results.
- Width: pure pass-through, no arithmetic in this block.

Decomposition:
- Shared package/header (`alu_defs`) holds:
  - ALU op localparams: ADD=4'b0010, SUB=4'b0110, AND=4'b0000, OR=4'b0001, SLT=4'b0111
  - State encodings: IDLE=2'd0, EXEC=2'd1, RESP=2'd2
- One natural sub-module: `rr_pick2`, a combinational 2-way round-robin winner select (inputs valid0, valid1, last_grant; outputs any, winner).
- The ALU is instantiated beside this block in the testbench and in the top level, not inside it.

Test Plan:
- Single request, add: req0 a=5 b=7 op=0010, resp0_ready=1 → req0_ready in cycle T; resp0_valid at T+2 with result=12, zero=0; resp1_valid stays 0.
- Subtract to zero: req1 a=0x10 b=0x10 op=0110 → resp1_result=0, resp1_zero=1 at T+2.
- Simultaneous requests after reset: req0 ADD 1+2 and req1 OR 0xF0|0x0F, both held valid → requester 0 served first (3), then requester 1 (0xFF). Four back-to-back pairs produce grant order 0,1,0,1,0,1,0,1.
- Backpressure: req0 SLT a=3 b=9, resp0_ready=0 for 5 cycles → resp0_valid=1 with result=1 held stable. req1_valid=1 during that time → req1_ready stays 0. After resp0_ready=1, IDLE, and req1 is accepted the next cycle.
- Reset mid-operation: accept req0 ADD 4+4, assert reset in the EXEC cycle → next cycle all outputs 0, state IDLE, no resp0_valid ever issued. A fresh request then completes normally, with requester 0 at priority.
- Illegal op: req0 op=4'b1111 a=9 b=9 → resp0_result=0, resp0_zero=1 at T+2.
